uart_frame_ctrl: RTL

Byte-level frame controller sitting directly downstream of the 8-bit UART receiver and upstream of the transmitter. It turns the received byte stream into register read/write commands against a 16-entry, 8-bit register bank. It answers every valid or rejected frame with a response frame pushed byte-by-byte into the transmitter. All UART status inputs come from the baud-derived clock domains and are re-synchronised to `clk`.

---
 rtl/uart_frame_ctrl_if.sv | 21 ++
 rtl/uart_frame_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl_if.sv
// UART byte-level handshake bundle between the frame controller and the rx/tx cores.
// slave = frame controller side, master = UART core side.
interface uart_frame_ctrl_if;
    logic       rxDone;
    logic [7:0] rxData;
    logic       rxErr;
    logic       txStart;
    logic [7:0] txData;
    logic       txBusy;
    logic       txDone;

    modport master (
        output rxDone, rxData, rxErr, txBusy, txDone,
        input  txStart, txData
    );

    modport slave (
        input  rxDone, rxData, rxErr, txBusy, txDone,
        output txStart, txData
    );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Frame controller: UART request frames -> 16x8 register bank access -> response frames.
// Optional feature macro: UART_FRAME_CHECKSUM_EN (adds CSUM byte to request and response).
module uart_frame_ctrl #(
    parameter int unsigned CLOCK_RATE = 100000000,
    parameter int unsigned TIMEOUT_US = 2000
) (
    input  logic             clk,
    input  logic             rstN,
    uart_frame_ctrl_if.slave uart,
    output logic [7:0]       ctrlOut,
    input  logic [7:0]       statusIn,
    output logic [7:0]       errCnt,
    output logic             busy
);

    localparam logic [31:0] TIMEOUT_CYC = 32'((CLOCK_RATE / 32'd1000000) * TIMEOUT_US);
`ifdef UART_FRAME_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_CSUM, S_EXEC,
        S_TX_LOAD, S_TX_WAIT_BUSY, S_TX_WAIT_DONE
    } state_t;

    state_t      state;
    logic [1:0]  rx_done_s, rx_err_s, tx_busy_s, tx_done_s;
    logic        rx_done_d, rx_err_d, tx_done_d;
    logic        byte_stb, err_stb, done_stb;
    logic [7:0]  rx_byte;
    logic [31:0] tmo_cnt;
    logic [7:0]  cmd, addr, data;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]  csum;
`endif
    logic [7:0]  regs [16];
    logic [7:0]  resp_status, resp_data;
    logic [2:0]  tx_idx;
    logic        csum_bad;
    logic [7:0]  status, rdata;

    function automatic logic [7:0] resp_byte(input logic [2:0] idx, input logic [7:0] st,
                                             input logic [7:0] ad, input logic [7:0] dt);
        case (idx)
            3'd0:    resp_byte = 8'h5A;
            3'd1:    resp_byte = st;
            3'd2:    resp_byte = ad;
            3'd3:    resp_byte = dt;
            default: resp_byte = st ^ ad ^ dt;
        endcase
    endfunction

    // Request decode: status priority csum > cmd > addr, data is zero on any error
    always_comb begin
        status = 8'h00;
        rdata  = 8'h00;
`ifdef UART_FRAME_CHECKSUM_EN
        csum_bad = (csum != (cmd ^ addr ^ data));
`else
        csum_bad = 1'b0;
`endif
        if (csum_bad)
            status = 8'h03;
        else if (cmd != 8'h01 && cmd != 8'h02)
            status = 8'h01;
        else if (addr[7:4] != 4'h0 || (cmd == 8'h01 && addr == 8'h0F))
            status = 8'h02;

        if (status != 8'h00)
            rdata = 8'h00;
        else if (cmd == 8'h01)
            rdata = data;
        else if (addr[3:0] == 4'hF)
            rdata = statusIn;
        else
            rdata = regs[addr[3:0]];
    end

    assign ctrlOut = regs[0];

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state        <= S_IDLE;
            rx_done_s    <= 2'b00;
            rx_err_s     <= 2'b00;
            tx_busy_s    <= 2'b00;
            tx_done_s    <= 2'b00;
            rx_done_d    <= 1'b0;
            rx_err_d     <= 1'b0;
            tx_done_d    <= 1'b0;
            byte_stb     <= 1'b0;
            err_stb      <= 1'b0;
            done_stb     <= 1'b0;
            rx_byte      <= 8'h00;
            tmo_cnt      <= 32'd0;
            cmd          <= 8'h00;
            addr         <= 8'h00;
            data         <= 8'h00;
`ifdef UART_FRAME_CHECKSUM_EN
            csum         <= 8'h00;
`endif
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
            resp_status  <= 8'h00;
            resp_data    <= 8'h00;
            tx_idx       <= 3'd0;
            uart.txStart <= 1'b0;
            uart.txData  <= 8'h00;
            errCnt       <= 8'h00;
            busy         <= 1'b0;
        end else begin
            // Two-flop synchronisers followed by a registered rising-edge strobe
            rx_done_s <= {rx_done_s[0], uart.rxDone};
            rx_err_s  <= {rx_err_s[0], uart.rxErr};
            tx_busy_s <= {tx_busy_s[0], uart.txBusy};
            tx_done_s <= {tx_done_s[0], uart.txDone};
            rx_done_d <= rx_done_s[1];
            rx_err_d  <= rx_err_s[1];
            tx_done_d <= tx_done_s[1];
            byte_stb  <= rx_done_s[1] & ~rx_done_d;
            err_stb   <= rx_err_s[1] & ~rx_err_d;
            done_stb  <= tx_done_s[1] & ~tx_done_d;
            if (rx_done_s[1] && !rx_done_d) rx_byte <= uart.rxData;

            case (state)
                S_IDLE: begin
                    tmo_cnt <= 32'd0;
                    if (byte_stb && rx_byte == 8'hA5) begin
                        state <= S_CMD;
                        busy  <= 1'b1;
                    end
                end
                S_CMD, S_ADDR, S_DATA, S_CSUM: begin
                    // Error edge beats a byte; a byte beats the timeout
                    if (err_stb || (!byte_stb && tmo_cnt >= TIMEOUT_CYC)) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        tmo_cnt <= 32'd0;
                        if (errCnt != 8'hFF) errCnt <= errCnt + 8'd1;
                    end else if (byte_stb) begin
                        tmo_cnt <= 32'd0;
                        case (state)
                            S_CMD:  begin cmd  <= rx_byte; state <= S_ADDR; end
                            S_ADDR: begin addr <= rx_byte; state <= S_DATA; end
`ifdef UART_FRAME_CHECKSUM_EN
                            S_DATA: begin data <= rx_byte; state <= S_CSUM; end
                            default: begin csum <= rx_byte; state <= S_EXEC; end
`else
                            default: begin data <= rx_byte; state <= S_EXEC; end
`endif
                        endcase
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_EXEC: begin
                    if (status == 8'h00 && cmd == 8'h01) regs[addr[3:0]] <= data;
                    resp_status  <= status;
                    resp_data    <= rdata;
                    tx_idx       <= 3'd0;
                    uart.txData  <= 8'h5A;
                    uart.txStart <= 1'b1;
                    state        <= S_TX_LOAD;
                end
                S_TX_LOAD: state <= S_TX_WAIT_BUSY;
                S_TX_WAIT_BUSY: begin
                    if (tx_busy_s[1]) begin
                        uart.txStart <= 1'b0;
                        state        <= S_TX_WAIT_DONE;
                    end
                end
                S_TX_WAIT_DONE: begin
                    if (done_stb) begin
                        if (tx_idx == LAST_IDX) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            tx_idx       <= tx_idx + 3'd1;
                            uart.txData  <= resp_byte(tx_idx + 3'd1, resp_status, addr, resp_data);
                            uart.txStart <= 1'b1;
                            state        <= S_TX_LOAD;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
